tile_reg_bank: RTL and testbench

Parametrised tile-layer register bank for the ChronoCube tile renderer. It holds a CPU-writable shadow copy and a renderer-visible active copy of every per-layer tile register. On each frame start it copies shadow to active one layer per cycle, so register changes take effect only between frames. It serves a registered, layer-selected register view to the tile pipeline.

---
 rtl/tile_reg_bank.sv | 219 +++++++++++++++++++++
 tb/tb_tile_reg_bank.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_reg_bank.sv
// -----------------------------------------------------------------------------
// tile_reg_bank
//   Per-layer tile register bank for the tile renderer. The CPU writes a shadow
//   bank. On each frame start, an FSM copies shadow into the renderer-visible
//   active bank, one layer per cycle, so that register changes only take effect
//   between frames. The renderer gets a registered view of the active registers
//   of the selected layer.
//
//   Build option: TILE_REG_DOUBLE_BUFFER_EN
//     defined   - shadow bank + copy FSM (double buffered).
//     undefined - single bank. CPU writes and reads go to the active bank,
//                 busy is tied low, and swap_done is frame_start delayed by
//                 one cycle.
//
// Ports
//   clk, _reset          clock, asynchronous active-low reset
//   wr, wr_data, addr    CPU write ({layer, reg} address, one per cycle)
//   rd, rd_data, rd_valid
//                        CPU read. rd in cycle N gives rd_data/rd_valid in
//                        cycle N+1. rd_valid is simply rd delayed one cycle; it
//                        has no back-pressure. Out-of-range reads return 0
//                        with rd_valid=1.
//   frame_start          pulse requesting a shadow->active copy
//   busy, swap_done      copy in progress / single-cycle copy-finished pulse
//   layer_sel            renderer layer select
//   layer_regs           active registers of the selected layer (reg i at
//                        bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH])
//   layer_enabled        bit 0 of active reg 0 of the selected layer
// -----------------------------------------------------------------------------
module tile_reg_bank #(
    parameter int NUM_LAYERS = 4,
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LAYER_BITS = 2,
    parameter int REG_BITS   = 3
) (
    input  logic                             clk,
    input  logic                             _reset,
    input  logic                             wr,
    input  logic                             rd,
    input  logic [LAYER_BITS+REG_BITS-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             frame_start,
    output logic                             busy,
    output logic                             swap_done,
    input  logic [LAYER_BITS-1:0]            layer_sel,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   layer_regs,
    output logic                             layer_enabled
);

    logic [LAYER_BITS-1:0]          w_layer;
    logic [REG_BITS-1:0]            w_reg;
    logic                           w_in_range;
    logic                           w_wr_hit;
    logic                           w_sel_valid;
    logic [DATA_WIDTH-1:0]          w_rd_src;
    logic [DATA_WIDTH-1:0]          w_active_nxt [NUM_LAYERS][NUM_REGS];
    logic [NUM_REGS*DATA_WIDTH-1:0] w_view;

    logic [DATA_WIDTH-1:0]          r_active [NUM_LAYERS][NUM_REGS];
    logic [DATA_WIDTH-1:0]          r_rd_data;
    logic                           r_rd_valid;
    logic [NUM_REGS*DATA_WIDTH-1:0] r_layer_regs;
    logic                           r_layer_enabled;

    assign w_layer     = addr[LAYER_BITS+REG_BITS-1:REG_BITS];
    assign w_reg       = addr[REG_BITS-1:0];
    assign w_in_range  = (int'(w_layer) < NUM_LAYERS) && (int'(w_reg) < NUM_REGS);
    assign w_wr_hit    = wr && w_in_range;
    assign w_sel_valid = int'(layer_sel) < NUM_LAYERS;

`ifdef TILE_REG_DOUBLE_BUFFER_EN
    typedef enum logic [1:0] {ST_IDLE, ST_COPY, ST_DONE} state_t;

    state_t                r_state;
    logic [LAYER_BITS-1:0] r_k;
    logic                  r_pending;
    logic                  r_busy;
    logic                  r_swap_done;
    logic [DATA_WIDTH-1:0] r_shadow [NUM_LAYERS][NUM_REGS];

    // Copy FSM. busy/swap_done are registered alongside the state so that
    // busy mirrors COPY and swap_done mirrors DONE.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_pending   <= 1'b0;
            r_busy      <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_swap_done <= 1'b0;
                    if (frame_start) begin
                        r_state <= ST_COPY;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_COPY: begin
                    if (frame_start) r_pending <= 1'b1;
                    if (int'(r_k) == NUM_LAYERS - 1) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_swap_done <= 1'b1;
                    end else begin
                        r_k <= r_k + LAYER_BITS'(1);
                    end
                end
                ST_DONE: begin
                    r_swap_done <= 1'b0;
                    // A request pending from COPY, or one arriving right now,
                    // restarts the copy without passing through IDLE.
                    if (r_pending || frame_start) begin
                        r_pending <= 1'b0;
                        r_state   <= ST_COPY;
                        r_k       <= '0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            for (int l = 0; l < NUM_LAYERS; l++)
                for (int r = 0; r < NUM_REGS; r++)
                    r_shadow[l][r] <= '0;
        end else if (w_wr_hit) begin
            r_shadow[w_layer][w_reg] <= wr_data;
        end
    end

    // Layer r_k is loaded from shadow while copying. A write hitting that
    // layer in the same cycle is forwarded so active matches the new shadow.
    always_comb begin
        for (int l = 0; l < NUM_LAYERS; l++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                w_active_nxt[l][r] = r_active[l][r];
                if (r_state == ST_COPY && r_k == LAYER_BITS'(l)) begin
                    if (w_wr_hit && w_layer == LAYER_BITS'(l) && w_reg == REG_BITS'(r))
                        w_active_nxt[l][r] = wr_data;
                    else
                        w_active_nxt[l][r] = r_shadow[l][r];
                end
            end
        end
    end

    assign w_rd_src  = w_in_range ? r_shadow[w_layer][w_reg] : '0;
    assign busy      = r_busy;
    assign swap_done = r_swap_done;
`else
    logic r_swap_done;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) r_swap_done <= 1'b0;
        else         r_swap_done <= frame_start;
    end

    always_comb begin
        for (int l = 0; l < NUM_LAYERS; l++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                w_active_nxt[l][r] = r_active[l][r];
                if (w_wr_hit && w_layer == LAYER_BITS'(l) && w_reg == REG_BITS'(r))
                    w_active_nxt[l][r] = wr_data;
            end
        end
    end

    assign w_rd_src  = w_in_range ? r_active[w_layer][w_reg] : '0;
    assign busy      = 1'b0;
    assign swap_done = r_swap_done;
`endif

    // The renderer view samples next-state active contents so a layer updated
    // at the end of cycle M is already visible in cycle M+1.
    always_comb begin
        w_view = '0;
        if (w_sel_valid) begin
            for (int r = 0; r < NUM_REGS; r++)
                w_view[r*DATA_WIDTH +: DATA_WIDTH] = w_active_nxt[layer_sel][r];
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            for (int l = 0; l < NUM_LAYERS; l++)
                for (int r = 0; r < NUM_REGS; r++)
                    r_active[l][r] <= '0;
            r_rd_data       <= '0;
            r_rd_valid      <= 1'b0;
            r_layer_regs    <= '0;
            r_layer_enabled <= 1'b0;
        end else begin
            for (int l = 0; l < NUM_LAYERS; l++)
                for (int r = 0; r < NUM_REGS; r++)
                    r_active[l][r] <= w_active_nxt[l][r];
            // Read samples pre-write storage, so a same-cycle write is not seen.
            r_rd_valid      <= rd;
            r_rd_data       <= rd ? w_rd_src : '0;
            r_layer_regs    <= w_view;
            r_layer_enabled <= w_view[0];
        end
    end

    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign layer_regs    = r_layer_regs;
    assign layer_enabled = r_layer_enabled;

endmodule

// File: tb/tb_tile_reg_bank.sv
module tb_tile_reg_bank;

`ifdef TILE_REG_DOUBLE_BUFFER_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    // ---------------- clock / reset / DUTs ----------------
    logic        clk = 1'b0;
    logic        _reset;
    logic        wr;
    logic        rd;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic        frame_start;
    logic [1:0]  layer_sel;

    logic [15:0]  t_rd_data  [2];
    logic         t_rd_valid [2];
    logic         t_busy     [2];
    logic         t_swap     [2];
    logic [127:0] t_regs     [2];
    logic         t_en       [2];

    always #5 clk = ~clk;

    tile_reg_bank dut0 (
        .clk(clk), ._reset(_reset), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(t_rd_data[0]), .rd_valid(t_rd_valid[0]), .frame_start(frame_start),
        .busy(t_busy[0]), .swap_done(t_swap[0]), .layer_sel(layer_sel),
        .layer_regs(t_regs[0]), .layer_enabled(t_en[0])
    );

    tile_reg_bank #(.NUM_LAYERS(3)) dut1 (
        .clk(clk), ._reset(_reset), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(t_rd_data[1]), .rd_valid(t_rd_valid[1]), .frame_start(frame_start),
        .busy(t_busy[1]), .swap_done(t_swap[1]), .layer_sel(layer_sel),
        .layer_regs(t_regs[1]), .layer_enabled(t_en[1])
    );

    // ---------------- reference model ----------------
    // Banks as plain arrays; copy timing tracked by the cycle number of the
    // frame_start that launched the current copy (m_s).
    logic [15:0]  m_sh [2][4][8];
    logic [15:0]  m_ac [2][4][8];
    int           m_s    [2];
    bit           m_pend [2];
    logic [15:0]  e_rd_data  [2];
    logic         e_rd_valid [2];
    logic         e_busy     [2];
    logic         e_swap     [2];
    logic [127:0] e_regs     [2];
    logic         e_en       [2];

    int cyc;
    int n_checks;
    int n_fail;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < 4; l++)
                for (int r = 0; r < 8; r++) begin
                    m_sh[i][l][r] = 16'h0;
                    m_ac[i][l][r] = 16'h0;
                end
            m_s[i] = -1;
            m_pend[i] = 1'b0;
            e_rd_data[i] = 16'h0;
            e_rd_valid[i] = 1'b0;
            e_busy[i] = 1'b0;
            e_swap[i] = 1'b0;
            e_regs[i] = '0;
            e_en[i] = 1'b0;
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        int nl, l, r, c, k;
        bit inr, busy_now, done;
        for (int i = 0; i < 2; i++) begin
            nl  = (i == 0) ? 4 : 3;
            l   = int'(addr[4:3]);
            r   = int'(addr[2:0]);
            inr = (l < nl);
            c   = cyc;
            e_rd_valid[i] = rd;
            e_rd_data[i]  = (rd && inr) ? (DBUF ? m_sh[i][l][r] : m_ac[i][l][r]) : 16'h0;
            if (wr && inr) begin
                if (DBUF) m_sh[i][l][r] = wr_data;
                else      m_ac[i][l][r] = wr_data;
            end
            if (DBUF) begin
                busy_now = (m_s[i] >= 0) && (c >= m_s[i] + 1) && (c <= m_s[i] + nl);
                done     = (m_s[i] >= 0) && (c == m_s[i] + nl + 1);
                if (busy_now) begin
                    k = c - m_s[i] - 1;
                    for (int r2 = 0; r2 < 8; r2++) m_ac[i][k][r2] = m_sh[i][k][r2];
                end
                if (done && (m_pend[i] || frame_start)) begin
                    m_s[i] = c;
                    m_pend[i] = 1'b0;
                end else if (busy_now && frame_start) begin
                    m_pend[i] = 1'b1;
                end else if (!busy_now && !done && frame_start) begin
                    m_s[i] = c;
                end
                e_busy[i] = (m_s[i] >= 0) && (c + 1 >= m_s[i] + 1) && (c + 1 <= m_s[i] + nl);
                e_swap[i] = (m_s[i] >= 0) && (c + 1 == m_s[i] + nl + 1);
            end else begin
                e_busy[i] = 1'b0;
                e_swap[i] = frame_start;
            end
            e_regs[i] = '0;
            if (int'(layer_sel) < nl)
                for (int r2 = 0; r2 < 8; r2++) e_regs[i][r2*16 +: 16] = m_ac[i][layer_sel][r2];
            e_en[i] = e_regs[i][0];
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rd_data[%0d]", i),    128'(t_rd_data[i]),  128'(e_rd_data[i]));
            chk($sformatf("rd_valid[%0d]", i),   128'(t_rd_valid[i]), 128'(e_rd_valid[i]));
            chk($sformatf("busy[%0d]", i),       128'(t_busy[i]),     128'(e_busy[i]));
            chk($sformatf("swap_done[%0d]", i),  128'(t_swap[i]),     128'(e_swap[i]));
            chk($sformatf("layer_regs[%0d]", i), t_regs[i],           e_regs[i]);
            chk($sformatf("layer_en[%0d]", i),   128'(t_en[i]),       128'(e_en[i]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic i_wr, input logic i_rd, input logic [4:0] i_addr,
                        input logic [15:0] i_wd, input logic i_fs, input logic [1:0] i_sel);
        wr = i_wr; rd = i_rd; addr = i_addr; wr_data = i_wd;
        frame_start = i_fs; layer_sel = i_sel;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input logic [1:0] i_sel);
        step(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, i_sel);
    endtask

    task automatic assert_reset();
        _reset = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic release_reset();
        wr = 1'b0; rd = 1'b0; frame_start = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        _reset = 1'b1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        wr;
        logic        rd;
        logic [4:0]  addr;
        logic [15:0] wd;
        logic        exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [7];

    int nb, ns, gap, first_b, last_b;
    bit bs [12];

    initial begin
        wr = 1'b0; rd = 1'b0; addr = 5'h0; wr_data = 16'h0;
        frame_start = 1'b0; layer_sel = 2'd0; _reset = 1'b0;
        cyc = 0; n_checks = 0; n_fail = 0;

        // {wr, rd, addr{layer,reg}, wdata, expected rd_valid, expected rd_data}
        tbl[0] = '{1'b0, 1'b1, 5'h0B, 16'h0000, 1'b1, 16'h0000};  // read {1,3} after reset
        tbl[1] = '{1'b1, 1'b0, 5'h01, 16'h1234, 1'b0, 16'h0000};  // write {0,1}
        tbl[2] = '{1'b0, 1'b1, 5'h01, 16'h0000, 1'b1, 16'h1234};  // read back
        tbl[3] = '{1'b1, 1'b1, 5'h1F, 16'hA5A5, 1'b1, 16'h0000};  // same-cycle wr+rd -> old
        tbl[4] = '{1'b0, 1'b1, 5'h1F, 16'h0000, 1'b1, 16'hA5A5};
        tbl[5] = '{1'b1, 1'b1, 5'h01, 16'h5678, 1'b1, 16'h1234};
        tbl[6] = '{1'b0, 1'b1, 5'h01, 16'h0000, 1'b1, 16'h5678};

        assert_reset();
        release_reset();

        for (int v = 0; v < 7; v++) begin
            step(tbl[v].wr, tbl[v].rd, tbl[v].addr, tbl[v].wd, 1'b0, 2'd0);
            chk($sformatf("tbl%0d_valid", v), 128'(t_rd_valid[0]), 128'(tbl[v].exp_valid));
            chk($sformatf("tbl%0d_data", v),  128'(t_rd_data[0]),  128'(tbl[v].exp_data));
        end

        // Out-of-range layer on the 3-layer instance.
        step(1'b1, 1'b0, 5'h1A, 16'hDEAD, 1'b0, 2'd0);
        step(1'b0, 1'b1, 5'h1A, 16'h0000, 1'b0, 2'd3);
        chk("oor_rd_data",  128'(t_rd_data[1]),  128'(16'h0));
        chk("oor_rd_valid", 128'(t_rd_valid[1]), 128'(1'b1));
        chk("oor_layer_regs", t_regs[1], 128'(0));

        // Enable bit only appears after a copy.
        step(1'b1, 1'b0, 5'h10, 16'h0001, 1'b0, 2'd2);
        idle(2'd2);
        chk("en_before_copy", 128'(t_en[0]), 128'(DBUF ? 1'b0 : 1'b1));
        step(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 2'd2);
        nb = int'(t_busy[0]); ns = int'(t_swap[0]);
        for (int j = 0; j < 5; j++) begin
            idle(2'd2);
            nb += int'(t_busy[0]); ns += int'(t_swap[0]);
        end
        chk("busy_cycles", 128'(nb), 128'(DBUF ? 4 : 0));
        chk("swap_pulses", 128'(ns), 128'(1));
        chk("en_after_copy", 128'(t_en[0]), 128'(1'b1));
        chk("reg0_after_copy", 128'(t_regs[0][15:0]), 128'(16'h0001));

        // Second frame_start during busy -> exactly one extra copy.
        step(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 2'd0);
        bs[0] = t_busy[0]; ns = int'(t_swap[0]);
        idle(2'd0);
        bs[1] = t_busy[0]; ns += int'(t_swap[0]);
        step(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 2'd0);
        bs[2] = t_busy[0]; ns += int'(t_swap[0]);
        for (int j = 3; j < 12; j++) begin
            idle(2'd0);
            bs[j] = t_busy[0]; ns += int'(t_swap[0]);
        end
        nb = 0; first_b = -1; last_b = -1; gap = 0;
        for (int j = 0; j < 12; j++) if (bs[j]) begin
            nb++;
            if (first_b < 0) first_b = j;
            last_b = j;
        end
        if (first_b >= 0) for (int j = first_b; j <= last_b; j++) if (!bs[j]) gap++;
        chk("pend_busy_cycles", 128'(nb), 128'(DBUF ? 8 : 0));
        chk("pend_busy_gap", 128'(gap), 128'(DBUF ? 1 : 0));
        chk("pend_swap_pulses", 128'(ns), 128'(2));

        // Write forwarded into the layer being copied.
        step(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 2'd1);
        idle(2'd1);
        step(1'b1, 1'b0, 5'h0D, 16'hBEEF, 1'b0, 2'd1);
        chk("fwd_beef", 128'(t_regs[0][95:80]), 128'(16'hBEEF));
        for (int j = 0; j < 4; j++) idle(2'd1);

        // Reset in the middle of a copy.
        step(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 2'd1);
        idle(2'd1);
        assert_reset();
        chk("rst_busy", 128'(t_busy[0]), 128'(1'b0));
        chk("rst_regs", t_regs[0], 128'(0));
        release_reset();
        ns = 0;
        for (int j = 0; j < 8; j++) begin
            idle(2'd1);
            ns += int'(t_swap[0]);
        end
        chk("rst_no_swap", 128'(ns), 128'(0));

        // Randomised traffic against the model.
        for (int j = 0; j < 400; j++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 16'($urandom), 1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)));
        end
        for (int j = 0; j < 12; j++) idle(2'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
